spi_slave_if: RTL and testbench



---
 rtl/spi_slave_if.sv | 111 +++++++++++
 tb/tb_spi_slave_if.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// SPI slave front end for the SPI RAM subsystem.
// Assembles 10-bit MOSI command frames into parallel words for the RAM and
// shifts the RAM's read data back out on MISO, MSB first.
module spi_slave_if #(
    parameter int CMD_WIDTH  = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ss_n,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic [CMD_WIDTH-1:0]  rx_data,
    output logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid
);

    localparam int BCNT_W = $clog2(CMD_WIDTH);
    localparam int TCNT_W = $clog2(DATA_WIDTH);

    // bit_cnt counts payload edges after the opcode MSB; LAST_BIT is the
    // edge sampling frame bit 0, RX_DONE marks a completed frame.
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(CMD_WIDTH - 2);
    localparam logic [BCNT_W-1:0] RX_DONE  = BCNT_W'(CMD_WIDTH - 1);
    localparam logic [TCNT_W-1:0] TX_REST  = TCNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t                  state;
    logic [BCNT_W-1:0]       bit_cnt;
    logic [CMD_WIDTH-2:0]    shift;
    logic                    rd_addr_pending;
    logic [DATA_WIDTH-1:0]   tx_shift;
    logic [TCNT_W-1:0]       tx_rem;
    logic                    tx_started;

    // Frame FSM: receive, decode, strobe the RAM and serialise read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            shift           <= '0;
            rd_addr_pending <= 1'b0;
            tx_shift        <= '0;
            tx_rem          <= '0;
            tx_started      <= 1'b0;
            MISO            <= 1'b0;
            rx_data         <= '0;
            rx_valid        <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            MISO     <= 1'b0;
            if (state != IDLE && ss_n) begin
                state      <= IDLE;
                bit_cnt    <= '0;
                shift      <= '0;
                tx_shift   <= '0;
                tx_rem     <= '0;
                tx_started <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!ss_n) state <= CHK_CMD;
                    end
                    CHK_CMD: begin
                        shift <= {shift[CMD_WIDTH-3:0], MOSI};
                        if (!MOSI)                state <= WRITE;
                        else if (rd_addr_pending) state <= READ_DATA;
                        else                      state <= READ_ADD;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (bit_cnt != RX_DONE) begin
                            shift   <= {shift[CMD_WIDTH-3:0], MOSI};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT) begin
                                rx_data  <= {shift, MOSI};
                                rx_valid <= 1'b1;
                                if (state == READ_ADD)  rd_addr_pending <= 1'b1;
                                if (state == READ_DATA) rd_addr_pending <= 1'b0;
                            end
                        end else if (state == READ_DATA) begin
                            // Only the first tx_valid after the strobe is taken;
                            // once started, MISO drains the byte then idles at 0.
                            if (!tx_started) begin
                                if (tx_valid) begin
                                    tx_started <= 1'b1;
                                    MISO       <= tx_data[DATA_WIDTH-1];
                                    tx_shift   <= {tx_data[DATA_WIDTH-2:0], 1'b0};
                                    tx_rem     <= TX_REST;
                                end
                            end else if (tx_rem != '0) begin
                                MISO     <= tx_shift[DATA_WIDTH-1];
                                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                                tx_rem   <= tx_rem - 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: frame table plus hand-written read-data,
// abort and mid-frame reset sequences.
module tb_spi_slave_if;

    localparam int CW = 10;
    localparam int DW = 8;

    localparam int S_IDLE      = 0;
    localparam int S_CHK_CMD   = 1;
    localparam int S_WRITE     = 2;
    localparam int S_READ_ADD  = 3;
    localparam int S_READ_DATA = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ss_n;
    logic          MOSI;
    logic          MISO;
    logic [CW-1:0] rx_data;
    logic          rx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_valid;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [CW-1:0] cmd;
        int            exp_state;
        logic          exp_pend;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    spi_slave_if #(.CMD_WIDTH(CW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ss_n     (ss_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drop ss_n for the select edge, then clock in nbits frame bits MSB first.
    task automatic send_bits(input logic [CW-1:0] cmd, input int nbits,
                             output int pulses, output logic miso_seen);
        pulses    = 0;
        miso_seen = 1'b0;
        ss_n = 1'b0;
        MOSI = 1'b1;
        step();
        if (rx_valid) pulses++;
        miso_seen |= MISO;
        for (int i = 0; i < nbits; i++) begin
            MOSI = cmd[CW-1-i];
            step();
            if (rx_valid) pulses++;
            miso_seen |= MISO;
        end
    endtask

    task automatic do_frame(input logic [CW-1:0] cmd, input int exp_state,
                            input logic exp_pend, input string tag);
        int   pulses;
        logic miso_seen;
        send_bits(cmd, CW, pulses, miso_seen);
        check({tag, ".rx_valid"}, rx_valid, 1);
        check({tag, ".rx_data"}, rx_data, cmd);
        check({tag, ".state"}, dut.state, exp_state);
        for (int k = 0; k < 2; k++) begin
            MOSI = ~MOSI;
            step();
            if (rx_valid) pulses++;
            miso_seen |= MISO;
        end
        check({tag, ".pulses"}, pulses, 1);
        check({tag, ".rx_hold"}, rx_data, cmd);
        check({tag, ".miso_quiet"}, miso_seen, 0);
        check({tag, ".pending"}, dut.rd_addr_pending, exp_pend);
        ss_n = 1'b1;
        step();
        check({tag, ".idle"}, dut.state, S_IDLE);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int            pulses;
        logic          miso_seen;
        logic [DW-1:0] got_byte;

        vecs[0] = '{cmd: 10'h0A5, exp_state: S_WRITE,    exp_pend: 1'b0};
        vecs[1] = '{cmd: 10'h13C, exp_state: S_WRITE,    exp_pend: 1'b0};
        vecs[2] = '{cmd: 10'h2A5, exp_state: S_READ_ADD, exp_pend: 1'b1};
        vecs[3] = '{cmd: 10'h055, exp_state: S_WRITE,    exp_pend: 1'b1};

        rst_n    = 1'b0;
        ss_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        step();
        step();
        check("rst.state", dut.state, S_IDLE);
        check("rst.MISO", MISO, 0);
        check("rst.rx_data", rx_data, 0);
        check("rst.rx_valid", rx_valid, 0);
        check("rst.pending", dut.rd_addr_pending, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 4; i++)
            do_frame(vecs[i].cmd, vecs[i].exp_state, vecs[i].exp_pend, $sformatf("vec%0d", i));

        // Read data: pending is set, so an 11 frame lands in READ_DATA.
        send_bits(10'h300, CW, pulses, miso_seen);
        check("rd.state", dut.state, S_READ_DATA);
        check("rd.rx_valid", rx_valid, 1);
        check("rd.rx_data", rx_data, 10'h300);
        step();
        check("rd.strobe_once", rx_valid, 0);
        check("rd.pending", dut.rd_addr_pending, 0);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        tx_data  = 8'hFF;
        got_byte[7] = MISO;
        for (int k = 6; k >= 0; k--) begin
            step();
            got_byte[k] = MISO;
        end
        check("rd.miso_byte", got_byte, 8'h3C);
        step();
        check("rd.miso_tail", MISO, 0);
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        check("rd.late_txv", MISO, 0);
        step();
        check("rd.late_txv2", MISO, 0);
        ss_n = 1'b1;
        step();
        check("rd.idle", dut.state, S_IDLE);

        // Abort a write frame after five bits.
        ss_n = 1'b0;
        MOSI = 1'b1;
        step();
        check("abort.chk_cmd", dut.state, S_CHK_CMD);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            MOSI = (i == 0) ? 1'b0 : i[0];
            step();
            if (rx_valid) pulses++;
        end
        ss_n = 1'b1;
        step();
        if (rx_valid) pulses++;
        check("abort.pulses", pulses, 0);
        check("abort.idle", dut.state, S_IDLE);
        do_frame(10'h001, S_WRITE, 1'b0, "post_abort");

        // Reset while rx_valid is high.
        send_bits(10'h155, CW, pulses, miso_seen);
        check("rstpulse.rx_valid_pre", rx_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rstpulse.rx_valid", rx_valid, 0);
        check("rstpulse.rx_data", rx_data, 0);
        ss_n = 1'b1;
        step();
        rst_n = 1'b1;
        step();

        // Reset in the middle of the MISO shift.
        do_frame(10'h2A5, S_READ_ADD, 1'b1, "rdadd2");
        send_bits(10'h3FF, CW, pulses, miso_seen);
        check("rstmiso.state", dut.state, S_READ_DATA);
        step();
        tx_data  = 8'hF0;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        step();
        check("rstmiso.miso_pre", MISO, 1);
        rst_n = 1'b0;
        #1;
        check("rstmiso.MISO", MISO, 0);
        check("rstmiso.rx_valid", rx_valid, 0);
        check("rstmiso.state", dut.state, S_IDLE);
        check("rstmiso.pending", dut.rd_addr_pending, 0);
        ss_n = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        do_frame(10'h3C3, S_READ_ADD, 1'b1, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
